aqp_sd_audio_dac: RTL and testbench
===================================

Name: aqp_sd_audio_dac

Overview:
- Audio output stage that sits between the core's 16-bit stereo sample source and the board's audio_l/audio_r pins.
- Accepts signed stereo samples through a valid/ready handshake and buffers them in a small FIFO.
- Pops one sample pair per sample-rate tick and drives each channel with a first-order sigma-delta bitstream at the full 28.63636 MHz system clock.
- Reports FIFO underrun so the core can detect audio starvation.

Parameters:
- CLK_DIV, 596, system clocks per sample period (28.63636 MHz / 596 ≈ 48.05 kHz); legal range 2..65535.
- FIFO_DEPTH, 4, sample-pair FIFO entries; must be a power of two, at least 2.

Ports:
- clk  input  1  system clock, 28.63636 MHz.
- reset_n  input  1  asynchronous active-low reset.
- in_left  input  16  left sample, signed two's complement.
- in_right  input  16  right sample, signed two's complement.
- in_valid  input  1  sample pair present on in_left/in_right.
- in_ready  output  1  FIFO can accept a pair this cycle.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current number of FIFO entries.
- next_sample  output  1  one-cycle pulse on each sample-rate tick.
- underrun  output  1  sticky underrun flag.
- underrun_clr  input  1  clears underrun.
- audio_l  output  1  left sigma-delta bitstream.
- audio_r  output  1  right sigma-delta bitstream.

Behaviour:
- Clock and reset: the single clock is clk. reset_n is asynchronous and active-low.
- Reset values: in_ready=1, fifo_level=0, next_sample=0, underrun=0, audio_l=audio_r=0, both accumulators=0, both held samples=16'h8000 (unsigned midpoint, i.e. signed 0), divider=0.
- Push: occurs when in_valid && in_ready. in_ready = (fifo_level != FIFO_DEPTH), registered-equivalent (no combinational path from in_valid). Data written at the write pointer; the pointer wraps modulo FIFO_DEPTH.
- Divider: counts 0..CLK_DIV-1 and wraps. The tick is asserted in the cycle where divider==CLK_DIV-1. next_sample is registered, so it is high in the cycle after the tick, for exactly 1 cycle.
- Pop on tick, FIFO non-empty: the head pair is loaded into the held samples, converted to unsigned by inverting bit 15. The read pointer advances.
- Pop on tick, FIFO empty: the held samples are unchanged and underrun is set.
- Simultaneous push and pop:
  - FIFO non-empty: fifo_level is unchanged and both succeed.
  - FIFO empty: there is no bypass. The pop underruns and the pushed pair is stored, giving fifo_level=1.
  - FIFO full: in_ready=0, so only the pop occurs.
- underrun: set and clear in the same cycle → set wins. Otherwise underrun_clr clears it on the next edge.
- Sigma-delta, per channel, every clock: sum[16:0] = {1'b0,acc[15:0]} + {1'b0,held}. acc <= sum[15:0]. audio_x <= sum[16], registered. Latency from held-sample load to first affected output bit is 1 clock.
- Output density: the long-run density of 1s on audio_x equals held/65536. held=16'h0000 gives a constant 0. held=16'hFFFF gives 1 except 1 clock in every 65536.
- Accumulator continuity: the accumulators are never cleared on sample change, only on reset.
- Reset mid-operation: all state returns to reset values immediately and asynchronously. FIFO contents are discarded. No next_sample pulse is emitted during reset.

Optional Feature:
- Macro: AQP_SD_AUDIO_DAC_DITHER_EN.
- Defined: a 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11, seed 16'hACE1 at reset) advances every clock. Its low 3 bits, sign-extended, are added to held before the accumulator add, with saturation at 16'h0000 and 16'hFFFF. Left uses lfsr[2:0] and right uses lfsr[5:3].
- Undefined: no LFSR logic is built, and the output is exactly the plain sigma-delta above.

Test Plan:
- Reset, then no input for 3*CLK_DIV clocks → next_sample pulses at clocks CLK_DIV, 2*CLK_DIV and 3*CLK_DIV after reset release. underrun=1 after the first tick. audio_l toggles with 50% density (0,1,0,1… from the first held value 16'h8000).
- Push 4 pairs with in_valid held high (FIFO_DEPTH=4) → in_ready drops after the 4th push and fifo_level=4. A 5th pair is not accepted until the next tick, after which fifo_level returns to 4.
- Push left=16'h7FFF, right=16'h8000, then count output 1s over 65536 clocks after the tick → audio_l count = 65535±1, audio_r count = 0.
- Push left=16'h4000 → audio_l density = 49152/65536 (0.75) measured over 4096 clocks, ±1 count.
- Assert underrun_clr in the same cycle as an underrunning tick → underrun=1. Assert underrun_clr alone → underrun=0 next cycle.
- Assert reset_n low mid-period with fifo_level=3 → all outputs return to reset values without waiting for a clock edge. After release, in_ready=1, fifo_level=0 and the first next_sample comes CLK_DIV clocks later.

Source files
------------

// File: rtl/aqp_sd_audio_dac.sv
// aqp_sd_audio_dac: stereo audio output stage.
// Signed 16-bit sample pairs enter through a valid/ready FIFO. One pair is
// popped on every sample-rate tick (every CLK_DIV clocks) into the held samples.
// Each channel is driven by a first-order sigma-delta bitstream at the system
// clock rate. A sticky underrun flag reports ticks that found the FIFO empty.
// Optional build macro: AQP_SD_AUDIO_DAC_DITHER_EN adds LFSR dither ahead of
// both modulators.
module aqp_sd_audio_dac #(
    parameter int CLK_DIV    = 596,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [15:0]                 in_left,
    input  logic [15:0]                 in_right,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        next_sample,
    output logic                        underrun,
    input  logic                        underrun_clr,
    output logic                        audio_l,
    output logic                        audio_r
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [15:0]   MIDPOINT = 16'h8000;

    // ------------------------------------------------------------------
    // Sample-rate divider
    // ------------------------------------------------------------------
    logic [DW-1:0] div_q;
    logic          tick;

    assign tick = (div_q == DIV_LAST);

    // Free-running 0..CLK_DIV-1 counter; tick marks its last count.
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Sample-pair FIFO
    // ------------------------------------------------------------------
    logic [15:0]   mem_l [FIFO_DEPTH];
    logic [15:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    assign fifo_empty = (level_q == '0);
    // NOTE: in_ready is decoded from level_q only, so there is no combinational path from in_valid.
    assign in_ready   = (level_q != LVL_FULL);
    assign push       = in_valid && in_ready;
    assign pop        = tick && !fifo_empty;

    // Storage write port.
    // NOTE: the storage array has no reset; pointers and level define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_l[wr_ptr_q] <= in_left;
            mem_r[wr_ptr_q] <= in_right;
        end
    end

    // Pointers wrap naturally (power-of-two depth); level tracks push minus pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_q + LW'(push) - LW'(pop);
        end
    end

    // ------------------------------------------------------------------
    // Held samples, tick pulse and underrun flag
    // ------------------------------------------------------------------
    logic [15:0] held_l_q;
    logic [15:0] held_r_q;
    logic        next_sample_q;
    logic        underrun_q;

    // On each tick load the head pair (signed -> offset binary) or flag underrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            held_l_q      <= MIDPOINT;
            held_r_q      <= MIDPOINT;
            next_sample_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            next_sample_q <= tick;
            if (pop) begin
                held_l_q <= mem_l[rd_ptr_q] ^ MIDPOINT;
                held_r_q <= mem_r[rd_ptr_q] ^ MIDPOINT;
            end
            if (tick && fifo_empty) begin
                underrun_q <= 1'b1;
            end else if (underrun_clr) begin
                underrun_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Modulator input: held sample, optionally dithered
    // ------------------------------------------------------------------
    logic [15:0] mod_in_l;
    logic [15:0] mod_in_r;

`ifdef AQP_SD_AUDIO_DAC_DITHER_EN
    logic [15:0] lfsr_q;

    // Galois LFSR x^16+x^14+x^13+x^11, one step per clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    // Add a signed 3-bit offset to an unsigned sample, clamping at both rails.
    function automatic logic [15:0] add_dither(input logic [15:0] s, input logic [2:0] d);
        logic [17:0] t;
        t = {2'b00, s} + {{15{d[2]}}, d};
        if (t[17]) begin
            add_dither = 16'h0000;
        end else if (t[16]) begin
            add_dither = 16'hFFFF;
        end else begin
            add_dither = t[15:0];
        end
    endfunction

    assign mod_in_l = add_dither(held_l_q, lfsr_q[2:0]);
    assign mod_in_r = add_dither(held_r_q, lfsr_q[5:3]);
`else
    assign mod_in_l = held_l_q;
    assign mod_in_r = held_r_q;
`endif

    // ------------------------------------------------------------------
    // First-order sigma-delta modulators
    // ------------------------------------------------------------------
    logic [15:0] acc_l_q;
    logic [15:0] acc_r_q;
    logic        audio_l_q;
    logic        audio_r_q;
    logic [16:0] sum_l;
    logic [16:0] sum_r;

    assign sum_l = {1'b0, acc_l_q} + {1'b0, mod_in_l};
    assign sum_r = {1'b0, acc_r_q} + {1'b0, mod_in_r};

    // Accumulate every clock; the carry out is the output bit. Accumulators persist across samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_l_q   <= '0;
            acc_r_q   <= '0;
            audio_l_q <= 1'b0;
            audio_r_q <= 1'b0;
        end else begin
            acc_l_q   <= sum_l[15:0];
            acc_r_q   <= sum_r[15:0];
            audio_l_q <= sum_l[16];
            audio_r_q <= sum_r[16];
        end
    end

    assign fifo_level  = level_q;
    assign next_sample = next_sample_q;
    assign underrun    = underrun_q;
    assign audio_l     = audio_l_q;
    assign audio_r     = audio_r_q;

endmodule

// File: tb/tb_aqp_sd_audio_dac.sv
// Self-checking bench for aqp_sd_audio_dac (default build, no dither).
// Hand sequences cover reset, tick timing, FIFO fill, underrun set/clear and
// asynchronous reset; a randomized phase compares every cycle against a
// behavioural model; a vector table checks long-run output densities.
module tb_aqp_sd_audio_dac;

    localparam int CLK_DIV    = 20;
    localparam int FIFO_DEPTH = 4;
    localparam int LW         = $clog2(FIFO_DEPTH) + 1;

    logic          clk;
    logic          reset_n;
    logic [15:0]   in_left;
    logic [15:0]   in_right;
    logic          in_valid;
    logic          in_ready;
    logic [LW-1:0] fifo_level;
    logic          next_sample;
    logic          underrun;
    logic          underrun_clr;
    logic          audio_l;
    logic          audio_r;

    aqp_sd_audio_dac #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_left      (in_left),
        .in_right     (in_right),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .fifo_level   (fifo_level),
        .next_sample  (next_sample),
        .underrun     (underrun),
        .underrun_clr (underrun_clr),
        .audio_l      (audio_l),
        .audio_r      (audio_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_tol(input string name, input int act, input int exp, input int tol);
        n_checks++;
        if (act >= exp - tol && act <= exp + tol) n_pass++;
        else $display("FAIL %s: got %0d expected %0d +/- %0d at %0t", name, act, exp, tol, $time);
    endtask

    // Wait (bounded) for a next_sample pulse, sampling on falling edges.
    task automatic wait_ns(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!next_sample && n < 4 * CLK_DIV);
    endtask

    task automatic do_reset();
        in_valid     = 1'b0;
        underrun_clr = 1'b0;
        in_left      = '0;
        in_right     = '0;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Behavioural reference model (cycle-level arithmetic, queue FIFO)
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } pair_t;

    pair_t       m_q[$];
    int unsigned m_cyc;
    int unsigned m_held_l, m_held_r, m_acc_l, m_acc_r;
    bit          m_ns, m_ur, m_al, m_ar;

    function automatic void model_reset();
        m_q.delete();
        m_cyc    = 0;
        m_held_l = 32768;
        m_held_r = 32768;
        m_acc_l  = 0;
        m_acc_r  = 0;
        m_ns     = 0;
        m_ur     = 0;
        m_al     = 0;
        m_ar     = 0;
    endfunction

    // One clock edge: outputs are computed from the state before the edge.
    function automatic void model_step(input bit v, input logic [15:0] l, input logic [15:0] r,
                                       input bit clr);
        bit          tick, ready, empty;
        int unsigned tl, tr;
        pair_t       p;
        ready = (m_q.size() != FIFO_DEPTH);
        empty = (m_q.size() == 0);
        tick  = (m_cyc % CLK_DIV) == CLK_DIV - 1;
        tl    = m_acc_l + m_held_l;
        tr    = m_acc_r + m_held_r;
        m_al  = (tl >= 65536);
        m_ar  = (tr >= 65536);
        m_acc_l = tl % 65536;
        m_acc_r = tr % 65536;
        m_ns  = tick;
        if (tick && !empty) begin
            p = m_q.pop_front();
            m_held_l = int'(p.l ^ 16'h8000);
            m_held_r = int'(p.r ^ 16'h8000);
        end
        if (tick && empty) m_ur = 1;
        else if (clr) m_ur = 0;
        if (v && ready) m_q.push_back({l, r});
        m_cyc++;
    endfunction

    function automatic logic [31:0] model_vec();
        bit rdy;
        rdy = (m_q.size() != FIFO_DEPTH);
        return {24'b0, rdy, LW'(m_q.size()), m_ns, m_ur, m_al, m_ar};
    endfunction

    logic [31:0] dut_vec;
    assign dut_vec = {24'b0, in_ready, fifo_level, next_sample, underrun, audio_l, audio_r};

    // ------------------------------------------------------------------
    // Density vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [15:0] left;
        logic [15:0] right;
        int          window;
        int          exp_l;
        int          exp_r;
    } dens_vec_t;

    dens_vec_t dv[4];

    // Global watchdog.
    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int n;
        int p_cnt;
        int pos[3];
        logic [7:0] bits_l, bits_r;
        int ones_l, ones_r;

        dv[0] = '{16'h7FFF, 16'h8000, 65536, 65535, 0};
        dv[1] = '{16'h4000, 16'hC000, 4096, 3072, 1024};
        dv[2] = '{16'h0000, 16'h2000, 4096, 2048, 2560};
        dv[3] = '{16'hFFFF, 16'h6000, 4096, 2048, 3584};

        reset_n      = 1'b0;
        in_valid     = 1'b0;
        underrun_clr = 1'b0;
        in_left      = '0;
        in_right     = '0;

        // ---- Reset state ----
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_next_sample", next_sample, 0);
        check("rst_underrun", underrun, 0);
        check("rst_audio_l", audio_l, 0);
        check("rst_audio_r", audio_r, 0);

        // ---- Idle for 3 sample periods: tick timing, underrun, 50% bitstream ----
        @(negedge clk);
        reset_n = 1'b1;
        p_cnt = 0;
        pos = '{-1, -1, -1};
        bits_l = '0;
        bits_r = '0;
        for (int k = 1; k <= 3 * CLK_DIV; k++) begin
            @(negedge clk);
            if (next_sample) begin
                if (p_cnt < 3) pos[p_cnt] = k;
                p_cnt++;
            end
            if (k <= 8) begin
                bits_l[k-1] = audio_l;
                bits_r[k-1] = audio_r;
            end
            if (k == CLK_DIV - 1) check("underrun_before_tick", underrun, 0);
            if (k == CLK_DIV) check("underrun_after_tick", underrun, 1);
        end
        check("ns_pulse_count", p_cnt, 3);
        check("ns_pulse_1", pos[0], CLK_DIV);
        check("ns_pulse_2", pos[1], 2 * CLK_DIV);
        check("ns_pulse_3", pos[2], 3 * CLK_DIV);
        check("idle_bits_l", bits_l, 8'hAA);
        check("idle_bits_r", bits_r, 8'hAA);

        // ---- underrun_clr alone, then together with an underrunning tick ----
        underrun_clr = 1'b1;
        @(negedge clk);
        check("clr_alone", underrun, 0);
        underrun_clr = 1'b0;
        repeat (CLK_DIV - 2) @(negedge clk);
        underrun_clr = 1'b1;
        @(negedge clk);
        check("clr_tick_align", next_sample, 1);
        check("clr_tick_set_wins", underrun, 1);
        underrun_clr = 1'b1;
        @(negedge clk);
        check("clr_after_tick", underrun, 0);
        underrun_clr = 1'b0;

        // ---- Fill the FIFO, hold a 5th pair until the next tick ----
        wait_ns(n);
        check("fill_sync", next_sample, 1);
        in_valid = 1'b1;
        in_left  = 16'h1234;
        in_right = 16'h5678;
        for (int i = 1; i <= FIFO_DEPTH; i++) begin
            @(negedge clk);
            check("fill_level", fifo_level, i);
        end
        check("fill_ready_low", in_ready, 0);
        wait_ns(n);
        check("fill_tick", next_sample, 1);
        check("pop_level", fifo_level, FIFO_DEPTH - 1);
        check("pop_ready", in_ready, 1);
        @(negedge clk);
        check("refill_level", fifo_level, FIFO_DEPTH);
        check("refill_ready", in_ready, 0);
        in_valid = 1'b0;

        // ---- Asynchronous reset mid-period with fifo_level=3 ----
        wait_ns(n);
        repeat (5) @(negedge clk);
        check("pre_rst_level", fifo_level, 3);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_in_ready", in_ready, 1);
        check("async_level", fifo_level, 0);
        check("async_next_sample", next_sample, 0);
        check("async_underrun", underrun, 0);
        check("async_audio", {audio_l, audio_r}, 0);
        repeat (2) begin
            @(negedge clk);
            check("rst_hold_no_ns", next_sample, 0);
        end
        reset_n = 1'b1;
        check("rel_in_ready", in_ready, 1);
        check("rel_level", fifo_level, 0);
        wait_ns(n);
        check("first_ns_after_rst", n, CLK_DIV);

        // ---- Randomized traffic against the reference model ----
        do_reset();
        model_reset();
        for (int i = 0; i < 800; i++) begin
            in_valid     = ($urandom_range(99) < ((i < 400) ? 35 : 4));
            in_left      = 16'($urandom);
            in_right     = 16'($urandom);
            underrun_clr = ($urandom_range(99) < 5);
            @(posedge clk);
            model_step(in_valid, in_left, in_right, underrun_clr);
            @(negedge clk);
            check("model", dut_vec, model_vec());
        end
        in_valid     = 1'b0;
        underrun_clr = 1'b0;

        // ---- Density table ----
        repeat (FIFO_DEPTH + 1) wait_ns(n);
        for (int t = 0; t < 4; t++) begin
            wait_ns(n);
            in_valid = 1'b1;
            in_left  = dv[t].left;
            in_right = dv[t].right;
            @(negedge clk);
            in_valid = 1'b0;
            wait_ns(n);
            check("dens_sync", next_sample, 1);
            ones_l = 0;
            ones_r = 0;
            for (int c = 0; c < dv[t].window; c++) begin
                @(negedge clk);
                ones_l += int'(audio_l);
                ones_r += int'(audio_r);
            end
            check_tol($sformatf("density_l[%0d]", t), ones_l, dv[t].exp_l, 1);
            check_tol($sformatf("density_r[%0d]", t), ones_r, dv[t].exp_r, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
